// File: rtl/vx_tensor_hopper_sched_pkg.sv
// Shared types and constants for the tensor commit sequencer.
package vx_tensor_hopper_sched_pkg;

    localparam int TENSOR_NUM_WARPS    = 4;
    localparam int TENSOR_QUEUE_DEPTH  = 16;
    localparam int TENSOR_COMMIT_BEATS = 4;
    localparam int TENSOR_NR_BITS      = 6;
    localparam int TENSOR_RD_BASE      = 32;

    // Per-uop commit metadata; carried through the sequencer untouched.
    typedef struct packed {
        logic [15:0] uuid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic        wb;
        logic [5:0]  rd;
        logic [4:0]  rsvd;
    } tensor_commit_meta_t;

    localparam int TENSOR_META_W = $bits(tensor_commit_meta_t);

    typedef enum logic {
        SEQ_IDLE,
        SEQ_ISSUE
    } seq_state_e;

    // Modulo-n increment for pointers whose range need not be a power of two.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/vx_tensor_hopper_sched_if.sv
// Dispatch-side uop handshake and commit-side beat handshake.
interface vx_tensor_hopper_sched_if
    import vx_tensor_hopper_sched_pkg::*;
#(
    parameter int NUM_WARPS = TENSOR_NUM_WARPS,
    parameter int META_W    = TENSOR_META_W,
    parameter int NUM_BEATS = TENSOR_COMMIT_BEATS,
    parameter int NR_BITS   = TENSOR_NR_BITS
);
    localparam int WID_W  = $clog2(NUM_WARPS);
    localparam int BEAT_W = $clog2(NUM_BEATS);

    logic              in_valid;
    logic              in_ready;
    logic [WID_W-1:0]  in_wid;
    logic [META_W-1:0] in_meta;

    logic              out_valid;
    logic              out_ready;
    logic [WID_W-1:0]  out_wid;
    logic [META_W-1:0] out_meta;
    logic [BEAT_W-1:0] out_beat;
    logic [NR_BITS-1:0] out_rd;
    logic              out_sop;
    logic              out_eop;
    logic              out_wb;

    logic              busy;
    logic              overflow_err;

    modport master (
        output in_valid, in_wid, in_meta, out_ready,
        input  in_ready, out_valid, out_wid, out_meta, out_beat, out_rd,
               out_sop, out_eop, out_wb, busy, overflow_err
    );

    modport slave (
        input  in_valid, in_wid, in_meta, out_ready,
        output in_ready, out_valid, out_wid, out_meta, out_beat, out_rd,
               out_sop, out_eop, out_wb, busy, overflow_err
    );

endinterface

// File: rtl/vx_tensor_hopper_sched_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping.
module vx_tensor_hopper_sched_rr_arbiter #(
    parameter int N     = 4,
    parameter int WID_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [WID_W-1:0] ptr,
    output logic             grant_valid,
    output logic [WID_W-1:0] grant_idx
);

    // Scan farthest-first so the closest requester to ptr wins last.
    always_comb begin
        int j;
        j           = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = WID_W'(j);
            end
        end
    end

endmodule

// File: rtl/vx_tensor_hopper_sched.sv
// Multi-warp tensor commit sequencer: per-warp metadata queues, round-robin
// warp grant, fixed NUM_BEATS commit sequence per uop with no inter-uop bubble.
module vx_tensor_hopper_sched
    import vx_tensor_hopper_sched_pkg::*;
#(
    parameter int NUM_WARPS   = TENSOR_NUM_WARPS,
    parameter int META_W      = TENSOR_META_W,
    parameter int QUEUE_DEPTH = TENSOR_QUEUE_DEPTH,
    parameter int NUM_BEATS   = TENSOR_COMMIT_BEATS,
    parameter int NR_BITS     = TENSOR_NR_BITS,
    parameter int RD_BASE     = TENSOR_RD_BASE
) (
    input logic                      clk,
    input logic                      reset,
    vx_tensor_hopper_sched_if.slave  bus
);

    localparam int WID_W  = $clog2(NUM_WARPS);
    localparam int BEAT_W = $clog2(NUM_BEATS);
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);

    seq_state_e        state_q, state_n;
    logic [WID_W-1:0]  cur_wid_q, cur_wid_n;
    logic [WID_W-1:0]  rr_ptr_q, rr_ptr_n;
    logic [BEAT_W-1:0] beat_q, beat_n;
    logic              ovf_q;
    logic              pop;

    logic [NUM_WARPS-1:0][PTR_W:0]   cnt_q;
    logic [NUM_WARPS-1:0][PTR_W-1:0] wr_q, rd_q;
    logic [META_W-1:0]               mem_q [NUM_WARPS][QUEUE_DEPTH];

    logic [NUM_WARPS-1:0] nonempty, full, push_vec, pop_vec, arb_req;
    logic                 accept, fire, last_beat, arb_valid;
    logic [WID_W-1:0]     arb_ptr, arb_idx;

    assign accept    = bus.in_valid && bus.in_ready;
    assign fire      = (state_q == SEQ_ISSUE) && bus.out_ready;
    assign last_beat = (beat_q == BEAT_W'(NUM_BEATS - 1));

    // Per-warp status and push/pop strobes.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            nonempty[w] = (cnt_q[w] != '0);
            full[w]     = (cnt_q[w] == (PTR_W + 1)'(QUEUE_DEPTH));
            push_vec[w] = accept && (bus.in_wid == WID_W'(w));
            pop_vec[w]  = pop && (cur_wid_q == WID_W'(w));
        end
    end

    // Ready looks only at the addressed warp, before any same-cycle pop.
    assign bus.in_ready = !full[bus.in_wid];

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (push_vec[w]) wr_q[w] <= wr_q[w] + 1'b1;
                if (pop_vec[w])  rd_q[w] <= rd_q[w] + 1'b1;
                cnt_q[w] <= cnt_q[w] + (PTR_W + 1)'(push_vec[w]) - (PTR_W + 1)'(pop_vec[w]);
            end
        end
    end

    // Queue storage; contents are meaningless until pointed at, so no reset.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (push_vec[w]) mem_q[w][wr_q[w]] <= bus.in_meta;
        end
    end

    // In ISSUE the arbiter result is only used on the last-beat fire, where the
    // current warp drops out if this pop empties it.
    always_comb begin
        arb_req = nonempty;
        arb_ptr = rr_ptr_q;
        if (state_q == SEQ_ISSUE) begin
            arb_ptr = WID_W'(wrap_inc(int'(cur_wid_q), NUM_WARPS));
            if (cnt_q[cur_wid_q] == (PTR_W + 1)'(1)) arb_req[cur_wid_q] = 1'b0;
        end
    end

    vx_tensor_hopper_sched_rr_arbiter #(
        .N     (NUM_WARPS),
        .WID_W (WID_W)
    ) u_arb (
        .req         (arb_req),
        .ptr         (arb_ptr),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEQ_IDLE;
            cur_wid_q <= '0;
            rr_ptr_q  <= '0;
            beat_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            cur_wid_q <= cur_wid_n;
            rr_ptr_q  <= rr_ptr_n;
            beat_q    <= beat_n;
            if (bus.in_valid && !bus.in_ready) ovf_q <= 1'b1;
        end
    end

    // Grant, beat advance, and back-to-back re-grant on the last beat.
    always_comb begin
        state_n   = state_q;
        cur_wid_n = cur_wid_q;
        rr_ptr_n  = rr_ptr_q;
        beat_n    = beat_q;
        pop       = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (arb_valid) begin
                    state_n   = SEQ_ISSUE;
                    cur_wid_n = arb_idx;
                    beat_n    = '0;
                end
            end
            SEQ_ISSUE: begin
                if (fire) begin
                    if (last_beat) begin
                        pop      = 1'b1;
                        rr_ptr_n = arb_ptr;
                        beat_n   = '0;
                        if (arb_valid) cur_wid_n = arb_idx;
                        else           state_n   = SEQ_IDLE;
                    end else begin
                        beat_n = BEAT_W'(wrap_inc(int'(beat_q), NUM_BEATS));
                    end
                end
            end
            default: state_n = SEQ_IDLE;
        endcase
    end

    assign bus.out_valid    = (state_q == SEQ_ISSUE);
    assign bus.out_wid      = cur_wid_q;
    assign bus.out_meta     = mem_q[cur_wid_q][rd_q[cur_wid_q]];
    assign bus.out_beat     = beat_q;
    assign bus.out_rd       = NR_BITS'(RD_BASE) + NR_BITS'(beat_q);
    assign bus.out_sop      = (beat_q == '0);
    assign bus.out_eop      = last_beat;
    assign bus.out_wb       = last_beat;
    assign bus.busy         = bus.out_valid || (|nonempty);
    assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_vx_tensor_hopper_sched.sv
// Scoreboard bench: stimulus runs a queue-level reference model and pushes
// expected per-cycle status and expected commit beats; a negedge monitor
// pops and compares against what the DUT presents.
module tb_vx_tensor_hopper_sched;

    localparam int NW    = 4;
    localparam int DEPTH = 16;
    localparam int NB    = 4;

    typedef struct {
        bit ready;
        bit valid;
        bit busy;
        bit ovf;
    } status_t;

    typedef struct {
        int          wid;
        logic [63:0] meta;
        int          beat;
        int          rd;
        bit          sop;
        bit          eop;
    } beat_t;

    logic clk;
    logic reset;

    vx_tensor_hopper_sched_if #(.NUM_WARPS(NW), .META_W(64), .NUM_BEATS(NB), .NR_BITS(6)) bus ();

    vx_tensor_hopper_sched #(
        .NUM_WARPS(NW), .META_W(64), .QUEUE_DEPTH(DEPTH),
        .NUM_BEATS(NB), .NR_BITS(6), .RD_BASE(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending uops per warp, and the uop currently committing.
    logic [63:0] mq [NW][$];
    bit          act;
    int          cur, beat, rr;
    bit          ovf;
    bit          chk_en;

    status_t stq[$];
    beat_t   bq[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_total++;
        if (act_v !== exp_v)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        else
            n_pass++;
    endtask

    function automatic int pick(input int from);
        for (int i = 0; i < NW; i++)
            if (mq[(from + i) % NW].size() > 0) return (from + i) % NW;
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < NW; i++)
            if (mq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs, record expectations, advance the model.
    task automatic step(input bit iv, input int w, input logic [63:0] m, input bit ordy, input bit rst);
        status_t s;
        beat_t   b;
        int      nx;
        bit      acc;
        bus.in_valid  = iv;
        bus.in_wid    = 2'(w);
        bus.in_meta   = m;
        bus.out_ready = ordy;
        reset         = rst;
        if (chk_en) begin
            s.ready = mq[w].size() < DEPTH;
            s.valid = act;
            s.busy  = act || any_pending();
            s.ovf   = ovf;
            stq.push_back(s);
            if (act && ordy) begin
                b.wid  = cur;
                b.meta = mq[cur][0];
                b.beat = beat;
                b.rd   = (32 + beat) % 64;
                b.sop  = (beat == 0);
                b.eop  = (beat == NB - 1);
                bq.push_back(b);
            end
        end
        if (rst) begin
            for (int i = 0; i < NW; i++) mq[i].delete();
            act = 0; cur = 0; beat = 0; rr = 0; ovf = 0;
            chk_en = 1;
        end else begin
            acc = iv && (mq[w].size() < DEPTH);
            if (iv && !acc) ovf = 1;
            if (act) begin
                if (ordy) begin
                    if (beat == NB - 1) begin
                        void'(mq[cur].pop_front());
                        rr = (cur + 1) % NW;
                        nx = pick(rr);
                        beat = 0;
                        if (nx >= 0) cur = nx;
                        else         act = 0;
                    end else begin
                        beat++;
                    end
                end
            end else begin
                nx = pick(rr);
                if (nx >= 0) begin
                    act = 1; cur = nx; beat = 0;
                end
            end
            if (acc) mq[w].push_back(m);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles, input bit ordy);
        for (int i = 0; i < cycles; i++) step(1'b0, 0, 64'h0, ordy, 1'b0);
    endtask

    function automatic logic [63:0] rmeta();
        return {$urandom, $urandom};
    endfunction

    // Monitor: per-cycle status, plus one expected beat per DUT fire.
    always @(negedge clk) begin
        status_t s;
        beat_t   e;
        if (stq.size() > 0) begin
            s = stq.pop_front();
            chk("in_ready",     64'(bus.in_ready),     64'(s.ready));
            chk("out_valid",    64'(bus.out_valid),    64'(s.valid));
            chk("busy",         64'(bus.busy),         64'(s.busy));
            chk("overflow_err", 64'(bus.overflow_err), 64'(s.ovf));
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (bq.size() == 0) begin
                n_total++;
                $display("FAIL beat_order: got unexpected beat wid=%0d beat=%0d, expected none at %0t",
                         bus.out_wid, bus.out_beat, $time);
            end else begin
                e = bq.pop_front();
                chk("out_wid",  64'(bus.out_wid),  64'(e.wid));
                chk("out_meta", bus.out_meta,      e.meta);
                chk("out_beat", 64'(bus.out_beat), 64'(e.beat));
                chk("out_rd",   64'(bus.out_rd),   64'(e.rd));
                chk("out_sop",  64'(bus.out_sop),  64'(e.sop));
                chk("out_eop",  64'(bus.out_eop),  64'(e.eop));
                chk("out_wb",   64'(bus.out_wb),   64'(e.eop));
            end
        end
    end

    initial begin
        bit bp [12] = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1};
        act = 0; cur = 0; beat = 0; rr = 0; ovf = 0; chk_en = 0;
        bus.in_valid = 0; bus.in_wid = '0; bus.in_meta = '0; bus.out_ready = 0;
        reset = 1;

        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);

        // Single uop on warp 0.
        step(1, 0, 64'hA5, 1, 0);
        idle(8, 1);

        // Backpressure on beats 1 and 2.
        step(1, 0, 64'h1234, bp[0], 0);
        for (int i = 1; i < 12; i++) step(0, 0, 0, bp[i], 0);
        idle(3, 1);

        // Warps 0, 2, 3 in one window, then warp 1 alone.
        step(1, 0, 64'h100, 1, 0);
        step(1, 2, 64'h102, 1, 0);
        step(1, 3, 64'h103, 1, 0);
        idle(14, 1);
        step(1, 1, 64'h101, 1, 0);
        idle(8, 1);

        // Two uops on warp 1: back-to-back.
        step(1, 1, 64'h201, 1, 0);
        step(1, 1, 64'h202, 1, 0);
        idle(12, 1);

        // Fill warp 2, 17th refused, warp 3 still accepted.
        for (int i = 0; i < DEPTH; i++) step(1, 2, 64'h300 + 64'(i), 0, 0);
        step(1, 2, 64'h3FF, 0, 0);
        step(1, 3, 64'h333, 0, 0);
        idle(2, 0);
        idle(80, 1);

        // Reset on beat 2 with uops queued, then a fresh uop on warp 1.
        step(1, 0, 64'h400, 1, 0);
        step(1, 1, 64'h401, 1, 0);
        step(1, 2, 64'h402, 1, 0);
        step(1, 3, 64'h403, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(1, 1, 64'h500, 1, 0);
        idle(8, 1);

        // Random traffic: mostly flowing, then mostly stalled to hit full queues.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 6, int'($urandom_range(0, NW - 1)), rmeta(),
                 $urandom_range(0, 9) < 8, i == 700);
        end
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, NW - 1)), rmeta(),
                 $urandom_range(0, 9) < 1, 1'b0);
        end
        idle(300, 1);

        chk("leftover_beats",  64'(bq.size()), 64'd0);
        chk("leftover_status", 64'(stq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
